// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute for
// lw, sw, R-type, beq, addi and j, plus a retired-instruction counter.
module mips_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_en,
  output logic        i_or_d,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_op,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] r_instr_count;
  logic        w_retire;

  logic        w_pc_en;
  logic        w_i_or_d;
  logic        w_mem_write;
  logic        w_ir_write;
  logic        w_mem_to_reg;
  logic        w_reg_write;
  logic        w_reg_dst;
  logic        w_alu_src_a;
  logic [1:0]  w_alu_src_b;
  logic [1:0]  w_pc_src;
  logic [2:0]  w_alu_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= StFetch;
      r_instr_count <= 32'd0;
    end else begin
      r_state       <= w_next_state;
      r_instr_count <= r_instr_count + {31'd0, w_retire};
    end
  end

  always_comb begin
    w_next_state = StFetch;
    w_retire     = 1'b0;
    w_pc_en      = 1'b0;
    w_i_or_d     = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_pc_src     = 2'b00;
    w_alu_op     = 3'b000;

    case (r_state)
      StFetch: begin
        w_ir_write   = 1'b1;
        w_alu_src_b  = 2'b01;
        w_alu_op     = AluAdd;
        w_pc_en      = 1'b1;
        w_next_state = StDecode;
      end
      StDecode: begin
        // ALU precomputes the branch target while the opcode is decoded
        w_alu_src_b = 2'b11;
        w_alu_op    = AluAdd;
        case (opcode)
          OpLw, OpSw: w_next_state = StMemAdr;
          OpRtype:    w_next_state = StExec;
          OpBeq:      w_next_state = StBranch;
          OpAddi:     w_next_state = StAddiEx;
          OpJ:        w_next_state = StJump;
          default:    w_next_state = StFetch;
        endcase
      end
      StMemAdr: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_alu_op     = AluAdd;
        w_next_state = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        w_i_or_d     = 1'b1;
        w_next_state = StMemWb;
      end
      StMemWb: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      StMemWr: begin
        w_i_or_d    = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = 1'b1;
      end
      StExec: begin
        w_alu_src_a = 1'b1;
        case (funct)
          6'b100010: w_alu_op = AluSub;
          6'b100100: w_alu_op = AluAnd;
          6'b100101: w_alu_op = AluOr;
          6'b101010: w_alu_op = AluSlt;
          default:   w_alu_op = AluAdd;
        endcase
        w_next_state = StAluWb;
      end
      StAluWb: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      StBranch: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = AluSub;
        w_pc_src    = 2'b01;
        w_pc_en     = zero;
        w_retire    = 1'b1;
      end
      StAddiEx: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_alu_op     = AluAdd;
        w_next_state = StAddiWb;
      end
      StAddiWb: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      StJump: begin
        w_pc_src = 2'b10;
        w_pc_en  = 1'b1;
        w_retire = 1'b1;
      end
      default: w_next_state = StFetch;
    endcase
  end

  // State-changing enables are gated so nothing is written while reset is held
  assign pc_en       = w_pc_en & ~reset;
  assign ir_write    = w_ir_write & ~reset;
  assign mem_write   = w_mem_write & ~reset;
  assign reg_write   = w_reg_write & ~reset;
  assign i_or_d      = w_i_or_d;
  assign mem_to_reg  = w_mem_to_reg;
  assign reg_dst     = w_reg_dst;
  assign alu_src_a   = w_alu_src_a;
  assign alu_src_b   = w_alu_src_b;
  assign pc_src      = w_pc_src;
  assign alu_op      = w_alu_op;
  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: walks each instruction class through its
// state sequence and checks outputs, latency, retire counting, reset and wrap.
module tb_mips_control_fsm;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        pc_en;
  logic        i_or_d;
  logic        mem_write;
  logic        ir_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        reg_dst;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  // {pc_en,i_or_d,mem_write,ir_write,mem_to_reg,reg_write,reg_dst,alu_src_a,
  //  alu_src_b,pc_src,alu_op}
  logic [14:0] outs;
  assign outs = {pc_en, i_or_d, mem_write, ir_write, mem_to_reg, reg_write, reg_dst,
                 alu_src_a, alu_src_b, pc_src, alu_op};

  localparam logic [14:0] ExpFetch  = {8'b10010000, 2'b01, 2'b00, 3'b010};
  localparam logic [14:0] ExpDecode = {8'b00000000, 2'b11, 2'b00, 3'b010};
  localparam logic [14:0] ExpMemAdr = {8'b00000001, 2'b10, 2'b00, 3'b010};
  localparam logic [14:0] ExpMemRd  = {8'b01000000, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] ExpMemWb  = {8'b00001100, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] ExpMemWr  = {8'b01100000, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] ExpAluWb  = {8'b00000110, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] ExpBrT    = {8'b10000001, 2'b00, 2'b01, 3'b110};
  localparam logic [14:0] ExpBrN    = {8'b00000001, 2'b00, 2'b01, 3'b110};
  localparam logic [14:0] ExpAddiEx = {8'b00000001, 2'b10, 2'b00, 3'b010};
  localparam logic [14:0] ExpAddiWb = {8'b00000100, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] ExpJump   = {8'b10000000, 2'b00, 2'b10, 3'b000};

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_count = 32'd0;

  mips_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .state      (state),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (state !== 4'd0) begin
      n_errors++; $display("FAIL reset_state got=%0d want=0", state);
    end
    n_checks++;
    if (instr_count !== 32'd0) begin
      n_errors++; $display("FAIL reset_count got=%h want=0", instr_count);
    end
    n_checks++;
    if ({pc_en, ir_write, mem_write, reg_write} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_enables got=%b want=0000", {pc_en, ir_write, mem_write, reg_write});
    end
    step();
    n_checks++;
    if (state !== 4'd0) begin
      n_errors++; $display("FAIL reset_hold_state got=%0d want=0", state);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (outs !== ExpFetch) begin
      n_errors++; $display("FAIL fetch_outs got=%b want=%b", outs, ExpFetch);
    end
  endtask

  task automatic test_lw();
    opcode = 6'b100011;
    step();
    n_checks++;
    if (state !== 4'd1 || outs !== ExpDecode) begin
      n_errors++; $display("FAIL lw_decode state=%0d outs=%b want 1/%b", state, outs, ExpDecode);
    end
    step();
    n_checks++;
    if (state !== 4'd2 || outs !== ExpMemAdr) begin
      n_errors++; $display("FAIL lw_memadr state=%0d outs=%b want 2/%b", state, outs, ExpMemAdr);
    end
    step();
    n_checks++;
    if (state !== 4'd3 || outs !== ExpMemRd) begin
      n_errors++; $display("FAIL lw_memrd state=%0d outs=%b want 3/%b", state, outs, ExpMemRd);
    end
    step();
    n_checks++;
    if (state !== 4'd4 || outs !== ExpMemWb) begin
      n_errors++; $display("FAIL lw_memwb state=%0d outs=%b want 4/%b", state, outs, ExpMemWb);
    end
    n_checks++;
    if (instr_count !== exp_count) begin
      n_errors++; $display("FAIL lw_count_early got=%h want=%h", instr_count, exp_count);
    end
    step();
    exp_count++;
    n_checks++;
    if (state !== 4'd0 || instr_count !== exp_count) begin
      n_errors++;
      $display("FAIL lw_retire state=%0d count=%h want 0/%h", state, instr_count, exp_count);
    end
  endtask

  task automatic test_sw();
    opcode = 6'b101011;
    step();
    step();
    n_checks++;
    if (state !== 4'd2) begin
      n_errors++; $display("FAIL sw_memadr state=%0d want=2", state);
    end
    step();
    n_checks++;
    if (state !== 4'd5 || outs !== ExpMemWr) begin
      n_errors++; $display("FAIL sw_memwr state=%0d outs=%b want 5/%b", state, outs, ExpMemWr);
    end
    step();
    exp_count++;
    n_checks++;
    if (state !== 4'd0 || instr_count !== exp_count) begin
      n_errors++;
      $display("FAIL sw_retire state=%0d count=%h want 0/%h", state, instr_count, exp_count);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] f_tab [6];
    logic [2:0] a_tab [6];
    f_tab[0] = 6'b101010; a_tab[0] = 3'b111;
    f_tab[1] = 6'b100000; a_tab[1] = 3'b010;
    f_tab[2] = 6'b100010; a_tab[2] = 3'b110;
    f_tab[3] = 6'b100100; a_tab[3] = 3'b000;
    f_tab[4] = 6'b100101; a_tab[4] = 3'b001;
    f_tab[5] = 6'b000011; a_tab[5] = 3'b010;
    opcode = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      funct = f_tab[i];
      step();
      step();
      n_checks++;
      if (state !== 4'd6 || outs !== {8'b00000001, 2'b00, 2'b00, a_tab[i]}) begin
        n_errors++;
        $display("FAIL rtype_exec funct=%b state=%0d outs=%b want alu_op=%b", f_tab[i], state,
                 outs, a_tab[i]);
      end
      step();
      n_checks++;
      if (state !== 4'd7 || outs !== ExpAluWb) begin
        n_errors++; $display("FAIL rtype_aluwb state=%0d outs=%b want 7/%b", state, outs, ExpAluWb);
      end
      step();
      exp_count++;
      n_checks++;
      if (state !== 4'd0 || instr_count !== exp_count) begin
        n_errors++;
        $display("FAIL rtype_retire state=%0d count=%h want 0/%h", state, instr_count, exp_count);
      end
    end
  endtask

  task automatic test_beq();
    opcode = 6'b000100;
    for (int t = 0; t < 2; t++) begin
      zero = (t == 0);
      step();
      step();
      n_checks++;
      if (state !== 4'd8 || outs !== (zero ? ExpBrT : ExpBrN)) begin
        n_errors++;
        $display("FAIL beq_branch zero=%b state=%0d outs=%b want 8/%b", zero, state, outs,
                 zero ? ExpBrT : ExpBrN);
      end
      step();
      exp_count++;
      n_checks++;
      if (state !== 4'd0 || instr_count !== exp_count) begin
        n_errors++;
        $display("FAIL beq_retire state=%0d count=%h want 0/%h", state, instr_count, exp_count);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi();
    opcode = 6'b001000;
    step();
    step();
    n_checks++;
    if (state !== 4'd9 || outs !== ExpAddiEx) begin
      n_errors++; $display("FAIL addi_ex state=%0d outs=%b want 9/%b", state, outs, ExpAddiEx);
    end
    step();
    n_checks++;
    if (state !== 4'd10 || outs !== ExpAddiWb) begin
      n_errors++; $display("FAIL addi_wb state=%0d outs=%b want 10/%b", state, outs, ExpAddiWb);
    end
    step();
    exp_count++;
    n_checks++;
    if (state !== 4'd0 || instr_count !== exp_count) begin
      n_errors++;
      $display("FAIL addi_retire state=%0d count=%h want 0/%h", state, instr_count, exp_count);
    end
  endtask

  task automatic test_jump();
    opcode = 6'b000010;
    step();
    step();
    n_checks++;
    if (state !== 4'd11 || outs !== ExpJump) begin
      n_errors++; $display("FAIL jump state=%0d outs=%b want 11/%b", state, outs, ExpJump);
    end
    step();
    exp_count++;
    n_checks++;
    if (state !== 4'd0 || instr_count !== exp_count) begin
      n_errors++;
      $display("FAIL jump_retire state=%0d count=%h want 0/%h", state, instr_count, exp_count);
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    step();
    n_checks++;
    if (state !== 4'd1) begin
      n_errors++; $display("FAIL illegal_decode state=%0d want=1", state);
    end
    n_checks++;
    if ({pc_en, ir_write, mem_write, reg_write} !== 4'b0000) begin
      n_errors++;
      $display("FAIL illegal_enables got=%b want=0000", {pc_en, ir_write, mem_write, reg_write});
    end
    step();
    n_checks++;
    if (state !== 4'd0 || instr_count !== exp_count) begin
      n_errors++;
      $display("FAIL illegal_back state=%0d count=%h want 0/%h", state, instr_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'b100011;
    step();
    step();
    step();
    n_checks++;
    if (state !== 4'd3) begin
      n_errors++; $display("FAIL mid_memrd state=%0d want=3", state);
    end
    #2;
    reset = 1'b1;
    #1;
    exp_count = 32'd0;
    n_checks++;
    if (state !== 4'd0 || instr_count !== 32'd0) begin
      n_errors++; $display("FAIL mid_reset state=%0d count=%h want 0/0", state, instr_count);
    end
    n_checks++;
    if ({pc_en, ir_write, mem_write, reg_write} !== 4'b0000) begin
      n_errors++;
      $display("FAIL mid_enables got=%b want=0000", {pc_en, ir_write, mem_write, reg_write});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0 || outs !== ExpFetch) begin
      n_errors++; $display("FAIL mid_release state=%0d outs=%b want 0/%b", state, outs, ExpFetch);
    end
    opcode = 6'b000010;
    step();
    n_checks++;
    if (state !== 4'd1) begin
      n_errors++; $display("FAIL mid_first_fetch state=%0d want=1", state);
    end
    step();
    step();
    exp_count++;
    n_checks++;
    if (instr_count !== exp_count) begin
      n_errors++; $display("FAIL mid_count got=%h want=%h", instr_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    force dut.r_instr_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_instr_count;
    #1;
    exp_count = 32'hFFFF_FFFE;
    n_checks++;
    if (instr_count !== exp_count) begin
      n_errors++; $display("FAIL wrap_preload got=%h want=%h", instr_count, exp_count);
    end
    opcode = 6'b000010;
    for (int k = 0; k < 2; k++) begin
      step();
      step();
      step();
      exp_count++;
      n_checks++;
      if (instr_count !== exp_count) begin
        n_errors++; $display("FAIL wrap_count k=%0d got=%h want=%h", k, instr_count, exp_count);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'b000000;
    funct  = 6'b000000;
    zero   = 1'b0;
    #1;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_addi();
    test_jump();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
